multi_channel_reduce: RTL and testbench
=======================================

# multi_channel_reduce

Parametrised, pipelined bitwise-reduction engine. It generalises the fixed three-operand AND submodule to NUM_CH independent channels of NUM_IN operands each, with a per-transaction mode (AND/OR/XOR/majority). Each channel has a valid/ready handshake and a saturating transaction counter. It sits between operand producers and result consumers and replaces hand-instantiated per-width AND instances in top-level wrappers.

## Interface
- WIDTH, 8, operand and result bit width (≥1)
- NUM_IN, 3, operands per channel (≥2)
- NUM_CH, 3, independent channels (≥1)
- CNT_W, 16, per-channel transaction counter width
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  NUM_CH  per-channel operand-set valid
- in_ready  output  NUM_CH  per-channel accept
- in_data  input  NUM_CH*NUM_IN*WIDTH  channel c, operand i at bits [(c*NUM_IN+i)*WIDTH +: WIDTH]
- in_mode  input  2*NUM_CH  channel c mode at [2c +: 2]
- out_valid  output  NUM_CH  per-channel result valid
- out_ready  input  NUM_CH  per-channel downstream accept
- out_data  output  NUM_CH*WIDTH  channel c result at [c*WIDTH +: WIDTH]
- txn_count  output  NUM_CH*CNT_W  channel c completed-transaction count
- cnt_clr  input  NUM_CH  synchronous per-channel counter clear

## Operation
- Channels are fully independent; no arbitration or cross-channel coupling.
- Modes: 00 AND, 01 OR, 10 XOR, 11 MAJ.
- MAJ result bit b is 1 iff the number of operands with bit b set is greater than NUM_IN/2 (integer division). For even NUM_IN, a tie gives 0.
- Pipeline per channel has two stages:
  - Stage A registers the operands and mode on an input handshake (in_valid & in_ready).
  - Stage B registers the reduced result.
- Each stage advances when it is empty or its downstream stage accepts.
  - in_ready[c] = !A_valid | B_advance.
  - B_advance = !out_valid | out_ready.
- Holding rule: out_data and out_valid stay stable while out_valid=1 and out_ready=0. Stage A holds its contents in the same way.
- txn_count increments on each output handshake (out_valid & out_ready) and saturates at 2^CNT_W−1.
- cnt_clr has priority over increment: if both occur in the same cycle, the counter becomes 0.
- Reset (asynchronous assert, synchronous deassert is the integrator's responsibility) forces:
  - out_valid=0, A_valid=0, out_data=0, txn_count=0
  - in_ready=1 from the first cycle after reset release
- Reset mid-transaction drops all in-flight data silently.

## Timing
- Latency: an input handshake in cycle N gives out_valid=1 in cycle N+2 when there is no backpressure.
- Throughput: one transaction per cycle per channel under continuous out_ready=1.
- in_ready depends combinationally on out_ready (no skid buffer). This path is accepted and documented for integrators.
- Full-pipeline stall: with both stages full and out_ready=0, in_ready=0. When out_ready rises, in_ready=1 in the same cycle, so the pipeline does not lose a bubble.
- in_mode is sampled only on the input handshake. Changing it while stalled does not affect in-flight data.
- All outputs except in_ready are registered.

## Structure
- Package reduce_pkg:
  - mode enum (RED_AND, RED_OR, RED_XOR, RED_MAJ)
  - pure function red_fn(operands, mode) parameterised by WIDTH/NUM_IN via a parameterised class or localparams
- Sub-module reduce_channel: one channel containing both pipeline stages and its counter, parameterised by WIDTH, NUM_IN, CNT_W.
- Top level: a generate loop over NUM_CH plus port slicing only.

## Test plan
- Reset release, default params:
  - All out_valid=0, txn_count=0, in_ready=3'b111.
  - ch0 in 8'hF0/8'hCC/8'hAA, mode AND → out_data ch0 = 8'h80 two cycles later.
- Mode sweep on one operand set 8'h0F/8'h33/8'h55, channels in parallel:
  - OR → 8'h7F
  - XOR → 8'h69
  - MAJ → 8'h17
- Backpressure:
  - Hold out_ready[1]=0 and stream 4 transactions → ch1 accepts exactly 2, then in_ready[1]=0.
  - out_data is stable during the stall.
  - Release → all 4 results arrive in order and txn_count=4.
- Counter edges:
  - CNT_W=2 with 5 handshakes → txn_count saturates at 3.
  - cnt_clr coincident with a handshake → count reads 0 the next cycle.
- Asynchronous reset:
  - Assert rst_n low mid-stream between clock edges → out_valid drops immediately and txn_count=0.
  - Post-release operation matches the first test.
- Parameter sweep: NUM_IN=4, WIDTH=16, NUM_CH=1; MAJ of 16'hFFFF/16'hFFFF/16'h0000/16'h0000 → 16'h0000 (tie resolves to 0).

Source files
------------

// File: rtl/reduce_pkg.sv
// Shared types and the per-bit reduction used by every channel of multi_channel_reduce.
package reduce_pkg;

  typedef enum logic [1:0] {
    RED_AND = 2'b00,
    RED_OR  = 2'b01,
    RED_XOR = 2'b10,
    RED_MAJ = 2'b11
  } red_mode_e;

  // Upper bound on operands per channel; a channel with NUM_IN > MaxIn is not supported.
  localparam int unsigned MaxIn = 32;

  // Reduces one bit column (bit b of every operand, operand i at bits[i]).
  // Only the low num_in entries take part; the rest are ignored.
  function automatic logic red_fn(input logic [MaxIn-1:0] bits, input int unsigned num_in,
                                  input red_mode_e mode);
    logic        acc_and;
    logic        acc_or;
    logic        acc_xor;
    int unsigned ones;
    logic        res;
    acc_and = 1'b1;
    acc_or  = 1'b0;
    acc_xor = 1'b0;
    ones    = 0;
    for (int unsigned i = 0; i < MaxIn; i++) begin
      if (i < num_in) begin
        acc_and = acc_and & bits[i];
        acc_or  = acc_or | bits[i];
        acc_xor = acc_xor ^ bits[i];
        ones    = ones + 32'(bits[i]);
      end
    end
    case (mode)
      RED_AND: res = acc_and;
      RED_OR:  res = acc_or;
      RED_XOR: res = acc_xor;
      RED_MAJ: res = (ones > num_in / 2);  // even NUM_IN tie resolves to 0
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reduce_channel.sv
// One reduction channel: operand stage, result stage and a saturating transaction counter.
module reduce_channel
  import reduce_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CNT_W-1:0]          txn_count,
  input  logic                      cnt_clr
);

  logic                    a_valid_q, a_valid_d;
  logic [NUM_IN*WIDTH-1:0] a_ops_q, a_ops_d;
  red_mode_e               a_mode_q, a_mode_d;
  logic                    b_valid_q, b_valid_d;
  logic [WIDTH-1:0]        b_data_q, b_data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    b_adv;
  logic [WIDTH-1:0]        red;

  // Combinational reduction of the operand stage contents.
  always_comb begin : p_reduce
    logic [MaxIn-1:0] col;
    red = '0;
    col = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      col = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        col[i] = a_ops_q[i*WIDTH+b];
      end
      red[b] = red_fn(col, NUM_IN, a_mode_q);
    end
  end

  // in_ready follows out_ready combinationally so a stalled pipeline refills without a bubble.
  always_comb begin
    b_adv    = !b_valid_q || out_ready;
    in_ready = !a_valid_q || b_adv;

    a_valid_d = a_valid_q;
    a_ops_d   = a_ops_q;
    a_mode_d  = a_mode_q;
    if (in_ready) begin
      a_valid_d = in_valid;
      if (in_valid) begin
        a_ops_d  = in_data;
        a_mode_d = red_mode_e'(in_mode);
      end
    end

    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    if (b_adv) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_data_d = red;
      end
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (b_valid_q && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_ops_q   <= '0;
      a_mode_q  <= RED_AND;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_ops_q   <= a_ops_d;
      a_mode_q  <= a_mode_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = b_valid_q;
  assign out_data  = b_data_q;
  assign txn_count = cnt_q;

endmodule

// File: rtl/multi_channel_reduce.sv
// NUM_CH independent pipelined bitwise-reduction channels; this level only slices ports.
module multi_channel_reduce #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               in_valid,
  output logic [NUM_CH-1:0]               in_ready,
  input  logic [NUM_CH*NUM_IN*WIDTH-1:0]  in_data,
  input  logic [2*NUM_CH-1:0]             in_mode,
  output logic [NUM_CH-1:0]               out_valid,
  input  logic [NUM_CH-1:0]               out_ready,
  output logic [NUM_CH*WIDTH-1:0]         out_data,
  output logic [NUM_CH*CNT_W-1:0]         txn_count,
  input  logic [NUM_CH-1:0]               cnt_clr
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    reduce_channel #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .CNT_W  (CNT_W)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[c]),
      .in_ready  (in_ready[c]),
      .in_data   (in_data[c*NUM_IN*WIDTH +: NUM_IN*WIDTH]),
      .in_mode   (in_mode[2*c +: 2]),
      .out_valid (out_valid[c]),
      .out_ready (out_ready[c]),
      .out_data  (out_data[c*WIDTH +: WIDTH]),
      .txn_count (txn_count[c*CNT_W +: CNT_W]),
      .cnt_clr   (cnt_clr[c])
    );
  end

endmodule

// File: tb/tb_multi_channel_reduce.sv
// Self-checking bench: directed scenarios plus randomized traffic against a counting model.
module tb_multi_channel_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Default-parameter instance.
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [71:0] in_data;
  logic [5:0]  in_mode;
  logic [23:0] out_data;
  logic [47:0] txn_count;

  // CNT_W=2 instance for saturation.
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clr;
  logic [23:0] s_in_data;
  logic [1:0]  s_in_mode;
  logic [7:0]  s_out_data;
  logic [1:0]  s_txn_count;

  // NUM_IN=4, WIDTH=16, NUM_CH=1 instance.
  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_cnt_clr;
  logic [63:0] p_in_data;
  logic [1:0]  p_in_mode;
  logic [15:0] p_out_data;
  logic [15:0] p_txn_count;

  multi_channel_reduce #(.WIDTH(8), .NUM_IN(3), .NUM_CH(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .txn_count(txn_count), .cnt_clr(cnt_clr)
  );

  multi_channel_reduce #(.WIDTH(8), .NUM_IN(3), .NUM_CH(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_mode(s_in_mode), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .txn_count(s_txn_count),
    .cnt_clr(s_cnt_clr)
  );

  multi_channel_reduce #(.WIDTH(16), .NUM_IN(4), .NUM_CH(1), .CNT_W(16)) dut_par (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_data(p_in_data), .in_mode(p_in_mode), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .out_data(p_out_data), .txn_count(p_txn_count),
    .cnt_clr(p_cnt_clr)
  );

  int checks = 0;
  int errors = 0;

  // Random-test scoreboard state.
  logic [7:0] exp_mem [3][512];
  int         wr_ptr [3];
  int         rd_ptr [3];
  int         model_cnt [3];

  // Reference: count set bits per column and apply the mode rule directly.
  function automatic logic [15:0] ref_red(input logic [63:0] ops, input int n, input int w,
                                          input logic [1:0] m);
    logic [15:0] r;
    int          ones;
    r = '0;
    for (int b = 0; b < w; b++) begin
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(ops[i*w+b]);
      case (m)
        2'd0:    r[b] = (ones == n);
        2'd1:    r[b] = (ones > 0);
        2'd2:    r[b] = ((ones % 2) == 1);
        default: r[b] = (ones > n / 2);
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int c, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] d, input logic [1:0] m);
    in_data[c*24 +: 8]    = a;
    in_data[c*24+8 +: 8]  = b;
    in_data[c*24+16 +: 8] = d;
    in_mode[c*2 +: 2]     = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0; out_ready = '0; cnt_clr = '0; in_data = '0; in_mode = '0;
    s_in_valid = 0; s_out_ready = 0; s_cnt_clr = 0; s_in_data = '0; s_in_mode = '0;
    p_in_valid = 0; p_out_ready = 0; p_cnt_clr = 0; p_in_data = '0; p_in_mode = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 3'b000) begin
      errors++; $display("FAIL reset_out_valid: got %b want 000", out_valid);
    end
    checks++;
    if (txn_count !== 48'd0) begin
      errors++; $display("FAIL reset_txn_count: got %h want 0", txn_count);
    end
    checks++;
    if (in_ready !== 3'b111) begin
      errors++; $display("FAIL reset_in_ready: got %b want 111", in_ready);
    end
    checks++;
    if (out_data !== 24'd0) begin
      errors++; $display("FAIL reset_out_data: got %h want 0", out_data);
    end
    checks++;
    if (p_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_aux: got %b/%b want 1/1", p_in_ready, s_in_ready);
    end
  endtask

  task automatic test_basic(input string tag);
    step();
    set_ops(0, 8'hF0, 8'hCC, 8'hAA, 2'd0);
    in_valid = 3'b001; out_ready = 3'b111;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL %s_accept: got in_ready=%b want 1", tag, in_ready[0]);
    end
    step();
    in_valid = 3'b000;
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++; $display("FAIL %s_latency_early: got out_valid=%b want 0", tag, out_valid[0]);
    end
    step();
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h80) begin
      errors++;
      $display("FAIL %s_and: got v=%b d=%h want v=1 d=80", tag, out_valid[0], out_data[7:0]);
    end
    step();
    @(negedge clk);
    checks++;
    if (txn_count[15:0] !== 16'd1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s_count: got cnt=%0d v=%b want cnt=1 v=0", tag, txn_count[15:0],
               out_valid[0]);
    end
  endtask

  task automatic test_modes();
    logic [7:0] exp_m [3];
    exp_m[0] = 8'h7F; exp_m[1] = 8'h69; exp_m[2] = 8'h17;
    step();
    set_ops(0, 8'h0F, 8'h33, 8'h55, 2'd1);
    set_ops(1, 8'h0F, 8'h33, 8'h55, 2'd2);
    set_ops(2, 8'h0F, 8'h33, 8'h55, 2'd3);
    in_valid = 3'b111; out_ready = 3'b111;
    step();
    in_valid = 3'b000;
    step();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid[c] !== 1'b1 || out_data[c*8 +: 8] !== exp_m[c]) begin
        errors++;
        $display("FAIL mode_ch%0d: got v=%b d=%h want v=1 d=%h", c, out_valid[c],
                 out_data[c*8 +: 8], exp_m[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  ops [4][3];
    logic [1:0]  md [4];
    logic [7:0]  exp_b [4];
    logic [15:0] tmp;
    logic [7:0]  held;
    int sent, got;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) ops[k][j] = 8'($urandom);
      md[k] = 2'($urandom_range(0, 3));
      tmp = ref_red({40'd0, ops[k][2], ops[k][1], ops[k][0]}, 3, 8, md[k]);
      exp_b[k] = tmp[7:0];
    end
    step();
    in_valid = '0; out_ready = 3'b111; cnt_clr = 3'b111;
    step();
    cnt_clr = '0;
    out_ready[1] = 1'b0;
    sent = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid[1] = (sent < 4);
      if (sent < 4) set_ops(1, ops[sent][0], ops[sent][1], ops[sent][2], md[sent]);
      @(negedge clk);
      if (cyc == 2) held = out_data[15:8];
      if (cyc > 2) begin
        checks++;
        if (out_valid[1] !== 1'b1 || out_data[15:8] !== held) begin
          errors++;
          $display("FAIL bp_stall_stable: got v=%b d=%h want v=1 d=%h", out_valid[1],
                   out_data[15:8], held);
        end
      end
      if (cyc == 5) begin
        checks++;
        if (in_ready[1] !== 1'b0) begin
          errors++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready[1]);
        end
      end
      if (in_valid[1] && in_ready[1]) sent++;
      step();
    end
    checks++;
    if (sent !== 2) begin
      errors++; $display("FAIL bp_accept_count: got %0d want 2", sent);
    end
    out_ready[1] = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      in_valid[1] = (sent < 4);
      if (sent < 4) set_ops(1, ops[sent][0], ops[sent][1], ops[sent][2], md[sent]);
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (in_ready[1] !== 1'b1) begin
          errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready[1]);
        end
      end
      if (out_valid[1] && out_ready[1]) begin
        checks++;
        if (out_data[15:8] !== exp_b[got]) begin
          errors++;
          $display("FAIL bp_order%0d: got %h want %h", got, out_data[15:8], exp_b[got]);
        end
        got++;
      end
      if (in_valid[1] && in_ready[1]) sent++;
      step();
    end
    in_valid = '0;
    checks++;
    if (got !== 4) begin
      errors++; $display("FAIL bp_timeout: got %0d results want 4", got);
    end
    @(negedge clk);
    checks++;
    if (txn_count[31:16] !== 16'd4) begin
      errors++; $display("FAIL bp_txn_count: got %0d want 4", txn_count[31:16]);
    end
  endtask

  task automatic test_cnt_clr();
    step();
    set_ops(0, 8'h12, 8'h34, 8'h56, 2'd1);
    in_valid = 3'b001; out_ready = 3'b111;
    step();
    in_valid = '0;
    step();
    cnt_clr = 3'b001;
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b1) begin
      errors++; $display("FAIL clr_coincident_valid: got %b want 1", out_valid[0]);
    end
    step();
    cnt_clr = '0;
    @(negedge clk);
    checks++;
    if (txn_count[15:0] !== 16'd0) begin
      errors++; $display("FAIL clr_priority: got %0d want 0", txn_count[15:0]);
    end
  endtask

  // Negedge-side scoring of one random-traffic cycle on the default instance.
  task automatic score_cycle();
    logic [15:0] tmp;
    bit          ohs;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (txn_count[c*16 +: 16] !== 16'(model_cnt[c])) begin
        errors++;
        $display("FAIL rnd_cnt_ch%0d: got %0d want %0d", c, txn_count[c*16 +: 16],
                 model_cnt[c]);
      end
      ohs = out_valid[c] && out_ready[c];
      if (ohs) begin
        checks++;
        if (rd_ptr[c] == wr_ptr[c]) begin
          errors++; $display("FAIL rnd_spurious_ch%0d: got %h want none", c, out_data[c*8 +: 8]);
        end else begin
          if (out_data[c*8 +: 8] !== exp_mem[c][rd_ptr[c] % 512]) begin
            errors++;
            $display("FAIL rnd_data_ch%0d: got %h want %h", c, out_data[c*8 +: 8],
                     exp_mem[c][rd_ptr[c] % 512]);
          end
          rd_ptr[c]++;
        end
      end
      if (in_valid[c] && in_ready[c]) begin
        tmp = ref_red({40'd0, in_data[c*24 +: 24]}, 3, 8, in_mode[c*2 +: 2]);
        exp_mem[c][wr_ptr[c] % 512] = tmp[7:0];
        wr_ptr[c]++;
      end
      if (cnt_clr[c]) model_cnt[c] = 0;
      else if (ohs && model_cnt[c] < 65535) model_cnt[c]++;
    end
  endtask

  task automatic test_random();
    step();
    in_valid = '0; out_ready = 3'b111; cnt_clr = 3'b111;
    step();
    cnt_clr = '0;
    for (int c = 0; c < 3; c++) begin
      wr_ptr[c] = 0; rd_ptr[c] = 0; model_cnt[c] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < 3; c++) begin
        in_valid[c]  = ($urandom_range(0, 3) != 0);
        out_ready[c] = ($urandom_range(0, 3) != 0);
        cnt_clr[c]   = ($urandom_range(0, 31) == 0);
        set_ops(c, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
      end
      score_cycle();
      step();
    end
    in_valid = '0; cnt_clr = '0; out_ready = 3'b111;
    for (int cyc = 0; cyc < 4; cyc++) begin
      score_cycle();
      step();
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rd_ptr[c] != wr_ptr[c]) begin
        errors++;
        $display("FAIL rnd_drain_ch%0d: got %0d outputs want %0d", c, rd_ptr[c], wr_ptr[c]);
      end
    end
  endtask

  task automatic test_saturate();
    int acc, ohs, want;
    acc = 0; ohs = 0;
    s_out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && !(acc == 5 && ohs == 5); cyc++) begin
      step();
      s_in_valid = (acc < 5);
      s_in_data  = 24'($urandom);
      s_in_mode  = 2'($urandom_range(0, 3));
      @(negedge clk);
      want = (ohs > 3) ? 3 : ohs;
      checks++;
      if (s_txn_count !== 2'(want)) begin
        errors++; $display("FAIL sat_progress: got %0d want %0d", s_txn_count, want);
      end
      if (s_out_valid && s_out_ready) ohs++;
      if (s_in_valid && s_in_ready) acc++;
    end
    s_in_valid = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (acc != 5 || ohs != 5 || s_txn_count !== 2'd3) begin
      errors++;
      $display("FAIL sat_final: got acc=%0d out=%0d cnt=%0d want 5/5/3", acc, ohs, s_txn_count);
    end
  endtask

  task automatic test_param();
    logic [15:0] want;
    p_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) begin
        p_in_data = {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
        p_in_mode = 2'd3;
        want = 16'h0000;
      end else begin
        p_in_data = {32'($urandom), 32'($urandom)};
        p_in_mode = 2'($urandom_range(0, 3));
        want = ref_red(p_in_data, 4, 16, p_in_mode);
      end
      p_in_valid = 1'b1;
      step();
      p_in_valid = 1'b0;
      step();
      @(negedge clk);
      checks++;
      if (p_out_valid !== 1'b1 || p_out_data !== want) begin
        errors++;
        $display("FAIL param_%0d: got v=%b d=%h want v=1 d=%h", k, p_out_valid, p_out_data, want);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (p_txn_count !== 16'd6) begin
      errors++; $display("FAIL param_count: got %0d want 6", p_txn_count);
    end
  endtask

  task automatic test_async_reset();
    step();
    in_valid = 3'b111; out_ready = 3'b111;
    for (int c = 0; c < 3; c++) set_ops(c, 8'($urandom), 8'($urandom), 8'($urandom), 2'd1);
    repeat (4) step();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 3'b000 || txn_count !== 48'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b cnt=%h want v=000 cnt=0", out_valid, txn_count);
    end
    in_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 3'b111 || out_valid !== 3'b000) begin
      errors++;
      $display("FAIL async_release: got rdy=%b v=%b want 111/000", in_ready, out_valid);
    end
    test_basic("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic("basic");
    test_modes();
    test_backpressure();
    test_cnt_clr();
    test_random();
    test_saturate();
    test_param();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
